// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: turns pipeline requests into word accesses on memory port B,
// with lane extraction/extension for loads, read-modify-write for sub-word RAM stores and misalign aborts.
module load_store_unit #(
  parameter int          RD_LAT  = 1,
  parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        mis_q, mis_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_half, req_word, req_mis, req_mmio;
  logic [31:0] req_wsized;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext, rmw_word;

  // op[1:0] gives the access size, op[2] selects zero extension for loads
  assign req_half = (req_op[1:0] == 2'b01);
  assign req_word = req_op[1];
  assign req_mis  = (req_half & req_addr[0]) | (req_word & (req_addr[1:0] != 2'b00));
  assign req_mmio = (req_addr[31:16] == MMIO_HI);

  always_comb begin
    req_wsized = req_wdata;
    if (req_op[1:0] == 2'b00)      req_wsized = {24'b0, req_wdata[7:0]};
    else if (req_op[1:0] == 2'b01) req_wsized = {16'b0, req_wdata[15:0]};
  end

  always_comb begin
    ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    if (op_q[1:0] == 2'b00)
      load_ext = op_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (op_q[1:0] == 2'b01)
      load_ext = op_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
    rmw_word = mem_rdata;
    if (op_q[1:0] == 2'b00) rmw_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    rmw_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      mis_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      mis_q        <= mis_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Sub-word RAM stores read the word first; misaligned ops never drive the memory port
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mis_d        = mis_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          write_d = req_write;
          mis_d   = req_mis;
          cnt_d   = '0;
          if (req_mis) begin
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_write && (req_word || req_mmio)) begin
              mem_wdata_d = req_wsized;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == CNT_LAST) begin
          if (write_q) begin
            mem_wdata_d = rmw_word;
            state_d     = WR;
          end else begin
            resp_rdata_d = load_ext;
            state_d      = RESP;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    stall         = ((state_q == IDLE) & req_valid) | (state_q == RD) | (state_q == WR);
    resp_valid    = (state_q == RESP);
    resp_misalign = (state_q == RESP) & mis_q;
    mem_we        = (state_q == WR);
    mem_addr      = mem_addr_q;
    mem_wdata     = mem_wdata_q;
    resp_rdata    = resp_rdata_q;
  end

endmodule
